// File: rtl/store_write_buffer_pkg.sv
// Shared store/memory types for the posted-store write buffer.
// Entries carry the word address only; the byte offset is dropped on entry.
package pipe_mem_pkg;

  localparam int WB_DEPTH_DEFAULT = 4;
  localparam int WB_DATA_W        = 32;
  localparam int WB_ADDR_W        = 32;
  localparam int WORD_OFS         = 2;

  typedef struct packed {
    logic                            valid;
    logic [WB_ADDR_W-WORD_OFS-1:0]   waddr;
    logic [WB_DATA_W-1:0]            data;
  } wb_entry_t;

  function automatic logic [WB_ADDR_W-WORD_OFS-1:0] word_addr(input logic [WB_ADDR_W-1:0] byte_addr);
    return byte_addr[WB_ADDR_W-1:WORD_OFS];
  endfunction

endpackage

// File: rtl/store_write_buffer_if.sv
// Pipeline-side and memory-side signals of the store write buffer.
// master = MEM stage / memory model, slave = the buffer itself.
interface store_write_buffer_if
  import pipe_mem_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH_DEFAULT,
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
);

  logic                    st_valid;
  logic [ADDR_W-1:0]       st_addr;
  logic [DATA_W-1:0]       st_data;
  logic                    st_ready;
  logic                    st_stall;
  logic                    ld_valid;
  logic [ADDR_W-1:0]       ld_addr;
  logic                    ld_hit;
  logic [DATA_W-1:0]       ld_hit_data;
  logic                    ld_stall;
  logic                    mem_wr_valid;
  logic [ADDR_W-1:0]       mem_wr_addr;
  logic [DATA_W-1:0]       mem_wr_data;
  logic                    mem_wr_ready;
  logic [$clog2(DEPTH):0]  count;
  logic                    empty;
  logic                    full;

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_wr_ready,
    input  st_ready, st_stall, ld_hit, ld_hit_data, ld_stall,
           mem_wr_valid, mem_wr_addr, mem_wr_data, count, empty, full
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_wr_ready,
    output st_ready, st_stall, ld_hit, ld_hit_data, ld_stall,
           mem_wr_valid, mem_wr_addr, mem_wr_data, count, empty, full
  );

endinterface

// File: rtl/store_write_buffer_cam.sv
// Load lookup for the write buffer: compares every valid entry against the
// load word address and returns the youngest match.
module wb_match_cam
  import pipe_mem_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT
) (
  input  wb_entry_t [DEPTH-1:0]           entries,
  input  logic [$clog2(DEPTH)-1:0]        tail,
  input  logic [WB_ADDR_W-WORD_OFS-1:0]   ld_waddr,
  output logic                            ld_hit,
  output logic [WB_DATA_W-1:0]            ld_hit_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;

  // Walking from tail upward visits live entries oldest-first, so the last match is the youngest.
  always_comb begin
    ld_hit      = 1'b0;
    ld_hit_data = '0;
    idx         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = tail + PTR_W'(i);
      if (entries[idx].valid && (entries[idx].waddr == ld_waddr)) begin
        ld_hit      = 1'b1;
        ld_hit_data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_write_buffer.sv
// Posted-store FIFO between MEM stage and data memory with store-to-load forwarding.
// Define WB_COALESCE_EN to merge a store into the youngest entry when word addresses match.
module store_write_buffer
  import pipe_mem_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH_DEFAULT,
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input logic                CLK,
  input logic                Reset_L,
  store_write_buffer_if.slave bus
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int WADDR_W = ADDR_W - WORD_OFS;

  wb_entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  pend_q, pend_d;

  logic                  empty, full, coal_hit, enq, deq, mem_wr_valid, ld_hit;
  logic [DATA_W-1:0]     ld_hit_data;
  logic [WADDR_W-1:0]    st_waddr, ld_waddr;

  assign st_waddr = word_addr(bus.st_addr);
  assign ld_waddr = word_addr(bus.ld_addr);

  wb_match_cam #(.DEPTH(DEPTH)) u_cam (
    .entries     (entries_q),
    .tail        (tail_q),
    .ld_waddr    (ld_waddr),
    .ld_hit      (ld_hit),
    .ld_hit_data (ld_hit_data)
  );

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // A missing load takes the memory port unless a drain request is already outstanding.
  assign mem_wr_valid = pend_q | (~empty & ~(bus.ld_valid & ~ld_hit));

`ifdef WB_COALESCE_EN
  logic [PTR_W-1:0] youngest;
  assign youngest = tail_q - PTR_W'(1);
  // Never rewrite the head while it is being offered to memory.
  assign coal_hit = bus.st_valid & ~empty & (entries_q[youngest].waddr == st_waddr)
                    & ~((count_q == CNT_W'(1)) & mem_wr_valid);
`else
  assign coal_hit = 1'b0;
`endif

  assign enq = bus.st_valid & bus.st_ready & ~coal_hit;
  assign deq = mem_wr_valid & bus.mem_wr_ready;

  assign bus.st_ready     = ~full | coal_hit;
  assign bus.st_stall     = bus.st_valid & ~bus.st_ready;
  assign bus.ld_hit       = ld_hit;
  assign bus.ld_hit_data  = ld_hit_data;
  assign bus.ld_stall     = bus.ld_valid & ~ld_hit & mem_wr_valid;
  assign bus.mem_wr_valid = mem_wr_valid;
  assign bus.mem_wr_addr  = mem_wr_valid ? {entries_q[head_q].waddr, {WORD_OFS{1'b0}}} : '0;
  assign bus.mem_wr_data  = mem_wr_valid ? entries_q[head_q].data : '0;
  assign bus.count        = count_q;
  assign bus.empty        = empty;
  assign bus.full         = full;

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    pend_d    = mem_wr_valid & ~bus.mem_wr_ready;
    count_d   = count_q + CNT_W'(enq) - CNT_W'(deq);
`ifdef WB_COALESCE_EN
    if (coal_hit) begin
      entries_d[youngest].data = bus.st_data;
    end
`endif
    if (deq) begin
      entries_d[head_q].valid = 1'b0;
      head_d = head_q + PTR_W'(1);
    end
    if (enq) begin
      entries_d[tail_q] = '{valid: 1'b1, waddr: st_waddr, data: bus.st_data};
      tail_d = tail_q + PTR_W'(1);
    end
  end

  always_ff @(negedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      entries_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      pend_q    <= 1'b0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      pend_q    <= pend_d;
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: directed scenarios followed by random traffic,
// checked against a queue-based model of the buffer.
module tb_store_write_buffer;
  import pipe_mem_pkg::*;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 32;

  logic CLK     = 1'b1;
  logic Reset_L = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  store_write_buffer_if #(.DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)) bus ();

  store_write_buffer #(.DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK     (CLK),
    .Reset_L (Reset_L),
    .bus     (bus)
  );

  // State commits on the falling edge; inputs change after the rising edge.
  always #5 CLK = ~CLK;

  typedef struct {
    logic [29:0] w;
    logic [31:0] d;
  } ent_t;

  ent_t mq[$];
  bit   m_pend;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic zero_inputs();
    bus.st_valid     = 1'b0;
    bus.st_addr      = '0;
    bus.st_data      = '0;
    bus.ld_valid     = 1'b0;
    bus.ld_addr      = '0;
    bus.mem_wr_ready = 1'b0;
  endtask

  // Compare every output against the model, then advance the model by one cycle.
  task automatic check_output(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                              input logic lv, input logic [31:0] la, input logic rdy);
    int          n;
    bit          hit, mwv, coal, rdy_exp;
    logic [31:0] hd;
    n   = mq.size();
    hit = 1'b0;
    hd  = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (!hit && mq[i].w == la[31:2]) begin
        hit = 1'b1;
        hd  = mq[i].d;
      end
    end
    mwv  = m_pend || (n > 0 && !(lv && !hit));
    coal = 1'b0;
`ifdef WB_COALESCE_EN
    if (sv && n > 0 && mq[n-1].w == sa[31:2] && !(n == 1 && mwv)) coal = 1'b1;
`endif
    rdy_exp = (n < DEPTH) || coal;
    check("st_ready",     bus.st_ready,     rdy_exp);
    check("st_stall",     bus.st_stall,     sv && !rdy_exp);
    check("ld_hit",       bus.ld_hit,       hit);
    check("ld_hit_data",  bus.ld_hit_data,  hd);
    check("ld_stall",     bus.ld_stall,     lv && !hit && mwv);
    check("mem_wr_valid", bus.mem_wr_valid, mwv);
    if (mwv && n > 0) begin
      check("mem_wr_addr", bus.mem_wr_addr, {mq[0].w, 2'b00});
      check("mem_wr_data", bus.mem_wr_data, mq[0].d);
    end
    check("count", bus.count, n);
    check("empty", bus.empty, n == 0);
    check("full",  bus.full,  n == DEPTH);
    if (coal) mq[n-1].d = sd;
    if (mwv && rdy) void'(mq.pop_front());
    if (sv && rdy_exp && !coal) mq.push_back('{w: sa[31:2], d: sd});
    m_pend = mwv && !rdy;
  endtask

  task automatic apply_stimulus(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                                input logic lv, input logic [31:0] la, input logic rdy);
    @(posedge CLK);
    bus.st_valid     = sv;
    bus.st_addr      = sa;
    bus.st_data      = sd;
    bus.ld_valid     = lv;
    bus.ld_addr      = la;
    bus.mem_wr_ready = rdy;
    #1;
    check_output(sv, sa, sd, lv, la, rdy);
  endtask

  task automatic idle(input logic rdy);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, rdy);
  endtask

  // Asserts reset between clock edges and checks it takes effect without a clock.
  task automatic async_reset();
    @(posedge CLK);
    #2;
    zero_inputs();
    Reset_L = 1'b0;
    #1;
    check("rst_count",        bus.count,        0);
    check("rst_mem_wr_valid", bus.mem_wr_valid, 0);
    check("rst_st_ready",     bus.st_ready,     1);
    check("rst_empty",        bus.empty,        1);
    mq.delete();
    m_pend = 1'b0;
    @(posedge CLK);
    #2;
    Reset_L = 1'b1;
  endtask

  initial begin
    zero_inputs();
    m_pend = 1'b0;
    #1;
    check("init_st_ready",     bus.st_ready,     1);
    check("init_empty",        bus.empty,        1);
    check("init_full",         bus.full,         0);
    check("init_count",        bus.count,        0);
    check("init_mem_wr_valid", bus.mem_wr_valid, 0);
    check("init_mem_wr_addr",  bus.mem_wr_addr,  0);
    check("init_ld_hit",       bus.ld_hit,       0);
    check("init_st_stall",     bus.st_stall,     0);
    #11;
    Reset_L = 1'b1;

    $display("[TB] reset while draining");
    apply_stimulus(1'b1, 32'h10, 32'h11, 1'b0, 32'h0, 1'b0);
    apply_stimulus(1'b1, 32'h14, 32'h22, 1'b0, 32'h0, 1'b0);
    apply_stimulus(1'b1, 32'h18, 32'h33, 1'b0, 32'h0, 1'b0);
    idle(1'b0);
    check("pre_rst_count", bus.count, 3);
    async_reset();

    $display("[TB] fill and stall");
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 32'h20 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0, 32'h0, 1'b0);
    end
    apply_stimulus(1'b1, 32'h30, 32'h55, 1'b0, 32'h0, 1'b0);
    check("fill_full",  bus.full,     1);
    check("fill_stall", bus.st_stall, 1);
    apply_stimulus(1'b1, 32'h30, 32'h55, 1'b0, 32'h0, 1'b1);
    check("fill_stall_on_handshake", bus.st_stall, 1);
    apply_stimulus(1'b1, 32'h30, 32'h55, 1'b0, 32'h0, 1'b0);
    check("fill_accept_after", bus.st_ready, 1);
    for (int i = 0; i < 6; i++) idle(1'b1);

    $display("[TB] forwarding");
    async_reset();
    apply_stimulus(1'b1, 32'h100, 32'hAAAA, 1'b0, 32'h0, 1'b0);
    apply_stimulus(1'b1, 32'h100, 32'hBBBB, 1'b0, 32'h0, 1'b0);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h102, 1'b0);
    check("fwd_hit",  bus.ld_hit,      1);
    check("fwd_data", bus.ld_hit_data, 32'hBBBB);

    $display("[TB] load priority");
    async_reset();
    apply_stimulus(1'b1, 32'h300, 32'h77, 1'b0, 32'h0, 1'b0);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h200, 1'b0);
    check("prio_mem_wr_valid", bus.mem_wr_valid, 0);
    check("prio_ld_stall",     bus.ld_stall,     0);
    idle(1'b0);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h200, 1'b0);
    check("prio_pend_stall", bus.ld_stall, 1);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h200, 1'b1);
    check("prio_stall_handshake", bus.ld_stall, 1);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h200, 1'b0);
    check("prio_stall_released", bus.ld_stall, 0);

    $display("[TB] drain stability");
    async_reset();
    apply_stimulus(1'b1, 32'h480, 32'hCAFE, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      check("hold_valid", bus.mem_wr_valid, 1);
      check("hold_addr",  bus.mem_wr_addr,  32'h480);
      check("hold_data",  bus.mem_wr_data,  32'hCAFE);
    end
    idle(1'b1);
    idle(1'b0);

    $display("[TB] coalescing");
    async_reset();
    apply_stimulus(1'b1, 32'h40, 32'h1, 1'b0, 32'h0, 1'b0);
    apply_stimulus(1'b1, 32'h44, 32'h2, 1'b0, 32'h0, 1'b0);
    apply_stimulus(1'b1, 32'h44, 32'h3, 1'b0, 32'h0, 1'b0);
    idle(1'b1);
`ifdef WB_COALESCE_EN
    check("coal_count", bus.count, 2);
`else
    check("coal_count", bus.count, 3);
`endif
    check("coal_first_word", bus.mem_wr_data, 32'h1);
    idle(1'b1);
`ifdef WB_COALESCE_EN
    check("coal_second_word", bus.mem_wr_data, 32'h3);
`else
    check("coal_second_word", bus.mem_wr_data, 32'h2);
`endif
    for (int i = 0; i < 3; i++) idle(1'b1);

    $display("[TB] random traffic");
    async_reset();
    for (int i = 0; i < 400; i++) begin
      logic        sv, lv, rdy;
      logic [31:0] sa, la, sd;
      sv  = ($urandom_range(0, 1) == 1);
      lv  = ($urandom_range(0, 4) < 2);
      rdy = ($urandom_range(0, 2) == 0);
      sa  = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      la  = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      sd  = $urandom;
      apply_stimulus(sv, sa, sd, lv, la, rdy);
    end
    for (int i = 0; i < 8; i++) idle(1'b1);
    check("final_empty", bus.empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
